// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit:
// FSM states, opcode/funct fields, ALU codes and mux selects.
package mips_ctrl_pkg;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_ADDIEX  = 4'd8;
  localparam logic [3:0] S_ADDIWB  = 4'd9;
  localparam logic [3:0] S_BRANCH  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_EXC     = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// Maps (ALUOp, funct) to the 3-bit ALU code and flags
// funct values the ALU does not implement.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o,
  output logic       illegal_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    illegal_o    = 1'b0;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALU_ADD;
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alucontrol_o = ALU_ADD;
          FN_SUB:  alucontrol_o = ALU_SUB;
          FN_AND:  alucontrol_o = ALU_AND;
          FN_OR:   alucontrol_o = ALU_OR;
          FN_SLT:  alucontrol_o = ALU_SLT;
          default: begin
            alucontrol_o = ALU_AND;
            illegal_o    = 1'b1;
          end
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: Moore-decoded datapath controls,
// branch resolution on zero, overflow/illegal-op exceptions.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic [2:0] ALUcontrol,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       exception,
  output logic       exc_cause
);

  logic [3:0] state_q, state_d;
  logic       ovf_q, ovf_d;
  logic       exc_cause_q, exc_cause_d;
  logic       sw_q, sw_d;
  logic [1:0] aluop;
  logic       alu_en;
  logic [2:0] dec_ctl;
  logic       dec_illegal;
  logic       pcen_c, memw_c, irw_c, regw_c, exc_c;

  alu_decoder u_dec (
    .aluop_i      (aluop),
    .funct_i      (funct),
    .alucontrol_o (dec_ctl),
    .illegal_o    (dec_illegal)
  );

  always_comb begin
    state_d     = state_q;
    ovf_d       = ovf_q;
    exc_cause_d = exc_cause_q;
    sw_d        = sw_q;
    aluop       = ALUOP_ADD;
    alu_en      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    PCSrc       = PCSRC_ALU;
    IorD        = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    pcen_c      = 1'b0;
    memw_c      = 1'b0;
    irw_c       = 1'b0;
    regw_c      = 1'b0;
    exc_c       = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_en  = 1'b1;
        ALUSrcB = SRCB_FOUR;
        irw_c   = 1'b1;
        pcen_c  = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_en  = 1'b1;
        ALUSrcB = SRCB_IMMSH;
        sw_d    = (opcode == OP_SW);
        unique case (1'b1)
          (opcode == OP_LW) || (opcode == OP_SW):
            state_d = S_MEMADR;
          opcode == OP_RTYPE: state_d = S_EXECUTE;
          opcode == OP_BEQ:   state_d = S_BRANCH;
          opcode == OP_ADDI:  state_d = S_ADDIEX;
          opcode == OP_J:     state_d = S_JUMP;
          default: begin
            state_d     = S_EXC;
            exc_cause_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_en  = 1'b1;
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = sw_q ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        regw_c   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        IorD    = 1'b1;
        memw_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alu_en  = 1'b1;
        ALUSrcA = 1'b1;
        aluop   = ALUOP_FUNCT;
        // only add/sub can trap; logical and slt ops clear it
        ovf_d   = overflow &
                  ((funct == FN_ADD) || (funct == FN_SUB));
        if (dec_illegal) begin
          state_d     = S_EXC;
          exc_cause_d = 1'b1;
          ovf_d       = 1'b0;
        end else begin
          state_d = S_ALUWB;
        end
      end
      S_ALUWB: begin
        RegDst = 1'b1;
        regw_c = ~ovf_q;
        if (ovf_q) begin
          state_d     = S_EXC;
          exc_cause_d = 1'b0;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_ADDIEX: begin
        alu_en  = 1'b1;
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ovf_d   = overflow;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regw_c = ~ovf_q;
        if (ovf_q) begin
          state_d     = S_EXC;
          exc_cause_d = 1'b0;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_en  = 1'b1;
        ALUSrcA = 1'b1;
        aluop   = ALUOP_SUB;
        PCSrc   = PCSRC_ALUOUT;
        pcen_c  = zero;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = PCSRC_JUMP;
        pcen_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_EXC: begin
        exc_c   = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign ALUcontrol = alu_en ? dec_ctl : 3'b000;
  assign PCEn       = pcen_c & ~reset;
  assign MemWrite   = memw_c & ~reset;
  assign IRWrite    = irw_c & ~reset;
  assign RegWrite   = regw_c & ~reset;
  assign exception  = exc_c & ~reset;
  assign exc_cause  = exc_cause_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      ovf_q       <= 1'b0;
      exc_cause_q <= 1'b0;
      sw_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ovf_q       <= ovf_d;
      exc_cause_q <= exc_cause_d;
      sw_q        <= sw_d;
    end
  end

endmodule
